// File: rtl/gate_sweep_unit.sv
// gate_sweep_unit
//   N_IN-input reduction-gate evaluator with a built-in exhaustive sweep.
//   Direct mode evaluates one vector with one cycle of latency. Sweep mode walks
//   every input combination 0..TT_W-1 in order and captures the truth table.
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   op            gate select: AND, OR, NAND, NOR, XOR, XNOR, BUF(bit0), NOT(bit0)
//   start         begin a sweep (taken only in IDLE, wins over eval_valid)
//   eval_valid    evaluate eval_in directly (taken only in IDLE)
//   eval_in       direct-mode input vector
//   busy          high while sweeping
//   vec_out/y_out vector and its gate result, qualified by y_valid
//   tt_out        captured truth table, bit k = f(k)
//   done          one-cycle pulse alongside the final sweep result
module gate_sweep_unit #(
  parameter  int N_IN = 2,
  localparam int TT_W = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      op,
  input  logic            start,
  input  logic            eval_valid,
  input  logic [N_IN-1:0] eval_in,
  output logic            busy,
  output logic [N_IN-1:0] vec_out,
  output logic            y_out,
  output logic            y_valid,
  output logic [TT_W-1:0] tt_out,
  output logic            done
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // One extra bit keeps the terminal compare against TT_W-1 wrap-free.
  localparam logic [N_IN:0] LAST = (N_IN+1)'(TT_W - 1);

  state_t          state, state_d;
  logic [N_IN:0]   cnt, cnt_d;
  logic [2:0]      op_q, op_q_d;
  logic            busy_d, y_d, yv_d, done_d;
  logic [N_IN-1:0] vec_d;
  logic [TT_W-1:0] tt_d;

  function automatic logic gate_f(input logic [2:0] o, input logic [N_IN-1:0] v);
    case (o)
      3'd0:    gate_f = &v;
      3'd1:    gate_f = |v;
      3'd2:    gate_f = ~&v;
      3'd3:    gate_f = ~|v;
      3'd4:    gate_f = ^v;
      3'd5:    gate_f = ~^v;
      3'd6:    gate_f = v[0];
      default: gate_f = ~v[0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      busy    <= 1'b0;
      vec_out <= '0;
      y_out   <= 1'b0;
      y_valid <= 1'b0;
      tt_out  <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      op_q    <= op_q_d;
      busy    <= busy_d;
      vec_out <= vec_d;
      y_out   <= y_d;
      y_valid <= yv_d;
      tt_out  <= tt_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_q_d  = op_q;
    busy_d  = busy;
    vec_d   = vec_out;
    y_d     = y_out;
    yv_d    = 1'b0;
    tt_d    = tt_out;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          op_q_d  = op;
          cnt_d   = '0;
          tt_d    = '0;
          busy_d  = 1'b1;
          state_d = SWEEP;
        end else if (eval_valid) begin
          vec_d = eval_in;
          y_d   = gate_f(op, eval_in);
          yv_d  = 1'b1;
        end
      end
      SWEEP: begin
        // op_q is frozen here; live op/start/eval_valid are ignored.
        vec_d = cnt[N_IN-1:0];
        y_d   = gate_f(op_q, cnt[N_IN-1:0]);
        tt_d[cnt[N_IN-1:0]] = gate_f(op_q, cnt[N_IN-1:0]);
        yv_d  = 1'b1;
        cnt_d = cnt + 1'b1;
        if (cnt == LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Self-checking bench for gate_sweep_unit: a 2-input and a 3-input instance,
// table-driven direct evaluations, hand-written sweep/reset sequences and a
// randomized mix checked against a counting-based gate model.
module tb_gate_sweep_unit;

  logic       clk, rst;
  logic [2:0] op, op3;
  logic       start, ev, start3, ev3;
  logic [1:0] ein, vec;
  logic [2:0] ein3, vec3;
  logic       busy, y, yv, done, busy3, y3, yv3, done3;
  logic [3:0] tt;
  logic [7:0] tt3;

  int checks = 0;
  int errors = 0;

  gate_sweep_unit #(.N_IN(2)) u2 (
    .clk(clk), .rst(rst), .op(op), .start(start), .eval_valid(ev), .eval_in(ein),
    .busy(busy), .vec_out(vec), .y_out(y), .y_valid(yv), .tt_out(tt), .done(done));

  gate_sweep_unit #(.N_IN(3)) u3 (
    .clk(clk), .rst(rst), .op(op3), .start(start3), .eval_valid(ev3), .eval_in(ein3),
    .busy(busy3), .vec_out(vec3), .y_out(y3), .y_valid(yv3), .tt_out(tt3), .done(done3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference gate: decided from the number of ones in the vector.
  function automatic logic f_ref(input int o, input int v, input int n);
    int ones = 0;
    for (int b = 0; b < n; b++) ones += (v >> b) & 1;
    case (o)
      0: return ones == n;
      1: return ones > 0;
      2: return ones != n;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      6: return (v & 1) == 1;
      default: return (v & 1) == 0;
    endcase
  endfunction

  function automatic logic [31:0] tt_ref(input int o, input int n);
    logic [31:0] t = '0;
    for (int k = 0; k < (1 << n); k++) t[k] = f_ref(o, k, n);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sweep on the 2-input unit. with_ev also raises eval_valid on the start
  // cycle; perturb scrambles op/start/eval_valid while sweeping.
  task automatic sweep2(input int o, input bit with_ev, input bit perturb);
    op = 3'(o); start = 1'b1; ev = with_ev; ein = 2'($urandom);
    tick();
    start = 1'b0; ev = 1'b0;
    chk("sw2_busy_start", busy, 1);
    chk("sw2_yv_start", yv, 0);
    chk("sw2_tt_clr", tt, 0);
    for (int k = 0; k < 4; k++) begin
      if (perturb) begin
        op = 3'($urandom); start = 1'($urandom); ev = 1'($urandom); ein = 2'($urandom);
      end
      tick();
      chk("sw2_yv", yv, 1);
      chk("sw2_vec", vec, k);
      chk("sw2_y", y, f_ref(o, k, 2));
      chk("sw2_done", done, k == 3);
      chk("sw2_busy", busy, k != 3);
    end
    start = 1'b0; ev = 1'b0; op = 3'(o);
    chk("sw2_tt", tt, tt_ref(o, 2));
  endtask

  task automatic sweep3(input int o);
    op3 = 3'(o); start3 = 1'b1;
    tick();
    start3 = 1'b0;
    op3 = 3'($urandom);
    for (int k = 0; k < 8; k++) begin
      chk("sw3_busy", busy3, 1);
      tick();
      chk("sw3_yv", yv3, 1);
      chk("sw3_vec", vec3, k);
      chk("sw3_y", y3, f_ref(o, k, 3));
      chk("sw3_done", done3, k == 7);
    end
    chk("sw3_busy_end", busy3, 0);
    chk("sw3_tt", tt3, tt_ref(o, 3));
  endtask

  task automatic eval2(input int o, input int v);
    op = 3'(o); ein = 2'(v); ev = 1'b1;
    tick();
    ev = 1'b0;
    chk("ev_yv", yv, 1);
    chk("ev_vec", vec, v);
    chk("ev_y", y, f_ref(o, v, 2));
    chk("ev_busy", busy, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] vin;
    logic       y;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [3:0] tt_hold;
    tbl[0] = '{3'd3, 2'b00, 1'b1};
    tbl[1] = '{3'd3, 2'b10, 1'b0};
    tbl[2] = '{3'd0, 2'b11, 1'b1};
    tbl[3] = '{3'd0, 2'b01, 1'b0};
    tbl[4] = '{3'd1, 2'b00, 1'b0};
    tbl[5] = '{3'd2, 2'b11, 1'b0};
    tbl[6] = '{3'd4, 2'b10, 1'b1};
    tbl[7] = '{3'd5, 2'b11, 1'b1};
    tbl[8] = '{3'd6, 2'b10, 1'b0};
    tbl[9] = '{3'd7, 2'b10, 1'b1};

    rst = 1'b1; op = '0; start = 0; ev = 0; ein = '0;
    op3 = '0; start3 = 0; ev3 = 0; ein3 = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_vec", vec, 0);
    chk("rst_y", y, 0);
    chk("rst_yv", yv, 0);
    chk("rst_tt", tt, 0);
    chk("rst_done", done, 0);
    chk("rst_tt3", tt3, 0);
    rst = 1'b0;
    tick();

    // AND sweep, then AND sweep with mid-sweep op/start disturbance
    sweep2(0, 0, 0);
    chk("and_tt", tt, 4'b1000);
    sweep2(0, 0, 1);
    chk("and_pert_tt", tt, 4'b1000);
    // start and eval_valid together: sweep wins; then a start in the done cycle
    sweep2(5, 1, 0);
    sweep2(1, 0, 0);
    tt_hold = tt;
    tick();
    chk("idle_yv", yv, 0);
    chk("idle_done", done, 0);
    chk("idle_tt_hold", tt, tt_hold);

    // table-driven direct evaluations, back to back
    for (int i = 0; i < 10; i++) begin
      op = tbl[i].op; ein = tbl[i].vin; ev = 1'b1;
      tick();
      chk("tbl_yv", yv, 1);
      chk("tbl_vec", vec, tbl[i].vin);
      chk("tbl_y", y, tbl[i].y);
      chk("tbl_busy", busy, 0);
    end
    ev = 1'b0;
    tick();
    chk("tbl_yv_off", yv, 0);
    chk("tbl_vec_hold", vec, tbl[9].vin);
    chk("tbl_y_hold", y, tbl[9].y);
    chk("tbl_tt_hold", tt, tt_hold);

    // 3-input XOR sweep
    sweep3(4);
    chk("xor3_tt", tt3, 8'b1001_0110);

    // reset after the second result of a sweep
    op = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_rst_vec", vec, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_yv", yv, 0);
    chk("mrst_vec", vec, 0);
    chk("mrst_tt", tt, 0);
    chk("mrst_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_quiet", {busy, yv, done}, 0);
    end
    sweep2(3, 0, 0);

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: for (int j = 0; j < int'($urandom_range(1, 3)); j++)
             eval2(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        1: sweep2(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        default: sweep3(int'($urandom_range(0, 7)));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rnd_idle_yv", yv, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
